// File: rtl/regfile_pkg.sv
// Shared register-bank definitions used by the bank, decode and write-back arbiter.
package regfile_pkg;

  localparam int unsigned NREG   = 17;
  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned SP_IDX = 16;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding slot for a write-back producer; frees itself when granted.
module wb_slot #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_data,
  input  logic          grant,
  output logic          ready,
  output logic          slot_valid,
  output logic [AW-1:0] slot_rd,
  output logic [DW-1:0] slot_data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  // Accept when empty or being drained this cycle; a reload wins over the clear.
  always_comb begin
    ready   = !reset && (!valid_q || grant);
    load    = in_valid && ready;
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      rd_d    = in_rd;
      data_d  = in_data;
    end else if (grant) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign slot_valid = valid_q;
  assign slot_rd    = rd_q;
  assign slot_data  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load write-backs onto the register bank's single write port.
module regfile_wb_arbiter #(
  parameter int unsigned NREG       = regfile_pkg::NREG,
  parameter int unsigned AW         = regfile_pkg::AW,
  parameter int unsigned DW         = regfile_pkg::DW,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q_rs,
  input  logic [AW-1:0] q_rt,
  output logic          q_hit_rs,
  output logic          q_hit_rt,
  output logic          idle
);

  import regfile_pkg::*;

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic          alu_occ, mem_occ;
  logic [AW-1:0] alu_slot_rd, mem_slot_rd;
  logic [DW-1:0] alu_slot_data, mem_slot_data;
  logic          grant_alu, grant_mem;
  wb_src_e       grant_src;

  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_rd_q, rf_rd_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;

  wb_slot #(.AW(AW), .DW(DW)) u_alu_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (alu_valid),
    .in_rd     (alu_rd),
    .in_data   (alu_data),
    .grant     (grant_alu),
    .ready     (alu_ready),
    .slot_valid(alu_occ),
    .slot_rd   (alu_slot_rd),
    .slot_data (alu_slot_data)
  );

  wb_slot #(.AW(AW), .DW(DW)) u_mem_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_valid),
    .in_rd     (mem_rd),
    .in_data   (mem_data),
    .grant     (grant_mem),
    .ready     (mem_ready),
    .slot_valid(mem_occ),
    .slot_rd   (mem_slot_rd),
    .slot_data (mem_slot_data)
  );

  // Mem has priority unless the waiting ALU write has been passed over STARVE_MAX times.
  always_comb begin
    grant_src = SRC_NONE;
    if (alu_occ && mem_occ) begin
      grant_src = (starve_q == SW'(STARVE_MAX)) ? SRC_ALU : SRC_MEM;
    end else if (alu_occ) begin
      grant_src = SRC_ALU;
    end else if (mem_occ) begin
      grant_src = SRC_MEM;
    end
    grant_alu = (grant_src == SRC_ALU);
    grant_mem = (grant_src == SRC_MEM);
  end

  // Count mem grants that bypass an occupied ALU slot.
  always_comb begin
    starve_d = '0;
    if (grant_mem && alu_occ) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end
  end

  // Next write-port value; R0 and out-of-range targets are dropped without a strobe.
  always_comb begin
    sel_rd     = grant_alu ? alu_slot_rd : mem_slot_rd;
    sel_data   = grant_alu ? alu_slot_data : mem_slot_data;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_alu || grant_mem) begin
      rf_we_d    = (sel_rd != '0) && (32'(sel_rd) < NREG);
      rf_rd_d    = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // Starve counter and write-port register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Read-after-write hazard lookup against both slots and the in-flight bank write.
  always_comb begin
    q_hit_rs = (q_rs != '0) &&
               ((alu_occ && (alu_slot_rd == q_rs)) ||
                (mem_occ && (mem_slot_rd == q_rs)) ||
                (rf_we_q && (rf_rd_q == q_rs)));
    q_hit_rt = (q_rt != '0) &&
               ((alu_occ && (alu_slot_rd == q_rt)) ||
                (mem_occ && (mem_slot_rd == q_rt)) ||
                (rf_we_q && (rf_rd_q == q_rt)));
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = !alu_occ && !mem_occ && !rf_we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a per-source write scoreboard.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rf_rd, q_rs, q_rt;
  logic [31:0] alu_data, mem_data, rf_wdata;
  logic        rf_we, q_hit_rs, q_hit_rt, idle;

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_alu[$];
  wr_t  exp_mem[$];
  bit   wr_src[$];
  wr_t  tmp;
  logic matched;
  int   ai, mi;
  logic af, mf;
  logic [8:0] exp_pat;

  regfile_wb_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .q_rs     (q_rs),
    .q_rt     (q_rt),
    .q_hit_rs (q_hit_rs),
    .q_hit_rt (q_hit_rt),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: match every bank write against the head of one source queue; log its source.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      matched = 1'b0;
      if (exp_alu.size() > 0 && exp_alu[0].rd == rf_rd && exp_alu[0].data == rf_wdata) begin
        tmp = exp_alu.pop_front();
        matched = 1'b1;
        wr_src.push_back(1'b0);
      end else if (exp_mem.size() > 0 && exp_mem[0].rd == rf_rd && exp_mem[0].data == rf_wdata) begin
        tmp = exp_mem.pop_front();
        matched = 1'b1;
        wr_src.push_back(1'b1);
      end
      chk($sformatf("sb_write rd=%0d data=%0h", rf_rd, rf_wdata), 32'(matched), 32'd1);
    end
    if (reset) begin
      exp_alu.delete();
      exp_mem.delete();
    end else begin
      if (alu_valid && alu_ready && alu_rd != 5'd0 && alu_rd < 5'd17)
        exp_alu.push_back('{rd: alu_rd, data: alu_data});
      if (mem_valid && mem_ready && mem_rd != 5'd0 && mem_rd < 5'd17)
        exp_mem.push_back('{rd: mem_rd, data: mem_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    q_rs = '0; q_rt = '0;

    // Reset state
    smp();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    cyc();
    reset = 1'b0;
    smp();
    chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
    cyc();

    // Single ALU write: rd=3 data=42, written in cycle 3
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd42; q_rs = 5'd3;
    smp();
    chk("single_c1_ready", 32'(alu_ready), 32'd1);
    cyc();
    alu_valid = 1'b0;
    smp();
    chk("single_c2_we", 32'(rf_we), 32'd0);
    chk("single_c2_hit", 32'(q_hit_rs), 32'd1);
    chk("single_c2_idle", 32'(idle), 32'd0);
    cyc();
    smp();
    chk("single_c3_we", 32'(rf_we), 32'd1);
    chk("single_c3_rd", 32'(rf_rd), 32'd3);
    chk("single_c3_data", rf_wdata, 32'd42);
    cyc();
    smp();
    chk("single_c4_idle", 32'(idle), 32'd1);
    chk("single_c4_hit", 32'(q_hit_rs), 32'd0);
    cyc();
    q_rs = '0;

    // Contention: both sources valid for 8 cycles
    wr_src.delete();
    ai = 0; mi = 0;
    for (int c = 1; c <= 8; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + ai); alu_data = 32'h0A00 + 32'(ai);
      mem_valid = 1'b1; mem_rd = 5'(9 + mi); mem_data = 32'h0B00 + 32'(mi);
      smp();
      if (c == 2) begin
        chk("cont_c2_alu_ready", 32'(alu_ready), 32'd0);
        chk("cont_c2_mem_ready", 32'(mem_ready), 32'd1);
      end
      af = alu_valid && alu_ready;
      mf = mem_valid && mem_ready;
      cyc();
      if (af) ai++;
      if (mf) mi++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (6) begin smp(); cyc(); end
    chk("cont_alu_accepted", 32'(ai), 32'd3);
    chk("cont_mem_accepted", 32'(mi), 32'd6);
    chk("cont_writes", 32'(wr_src.size()), 32'd9);
    exp_pat = 9'b011011011;
    for (int k = 0; k < 9; k++)
      if (k < wr_src.size())
        chk($sformatf("cont_grant_%0d_is_mem", k), 32'(wr_src[k]), 32'(exp_pat[k]));
    chk("cont_drained", 32'(exp_alu.size() + exp_mem.size()), 32'd0);
    chk("cont_idle", 32'(idle), 32'd1);

    // R0 and out-of-range targets are consumed silently
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'd7;
    smp();
    chk("r0_ready", 32'(mem_ready), 32'd1);
    cyc();
    mem_rd = 5'd20; mem_data = 32'd8;
    smp();
    chk("oor_ready", 32'(mem_ready), 32'd1);
    chk("oor_c2_we", 32'(rf_we), 32'd0);
    cyc();
    mem_valid = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      smp();
      chk($sformatf("oor_c%0d_we", c), 32'(rf_we), 32'd0);
      cyc();
    end
    smp();
    chk("oor_idle", 32'(idle), 32'd1);
    cyc();

    // Hazard lookup: mem rd=5
    q_rs = 5'd5; q_rt = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
    smp();
    chk("haz_c1_rs", 32'(q_hit_rs), 32'd0);
    cyc();
    mem_valid = 1'b0;
    smp();
    chk("haz_c2_rs", 32'(q_hit_rs), 32'd1);
    chk("haz_c2_rt", 32'(q_hit_rt), 32'd0);
    cyc();
    smp();
    chk("haz_c3_rs", 32'(q_hit_rs), 32'd1);
    chk("haz_c3_we", 32'(rf_we), 32'd1);
    chk("haz_c3_rt", 32'(q_hit_rt), 32'd0);
    cyc();
    smp();
    chk("haz_c4_rs", 32'(q_hit_rs), 32'd0);
    chk("haz_c4_rt", 32'(q_hit_rt), 32'd0);
    cyc();
    q_rs = '0;

    // Simultaneous grant and reload: back-to-back ALU stream
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        alu_valid = 1'b1; alu_rd = 5'(c); alu_data = 32'(c);
      end else begin
        alu_valid = 1'b0;
      end
      smp();
      if (c <= 4) chk($sformatf("reload_c%0d_ready", c), 32'(alu_ready), 32'd1);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("reload_c%0d_we", c), 32'(rf_we), 32'd1);
        chk($sformatf("reload_c%0d_rd", c), 32'(rf_rd), 32'(c - 2));
        chk($sformatf("reload_c%0d_data", c), rf_wdata, 32'(c - 2));
      end
      if (c == 7) chk("reload_c7_we", 32'(rf_we), 32'd0);
      cyc();
    end

    // Reset mid-operation with both slots full
    q_rs = 5'd6; q_rt = 5'd7;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 5) begin
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
      end
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      end
      smp();
      if (c == 4) chk("rstmid_c4_hit_rs", 32'(q_hit_rs), 32'd1);
      if (c == 5) begin
        chk("rstmid_c5_alu_ready", 32'(alu_ready), 32'd0);
        chk("rstmid_c5_mem_ready", 32'(mem_ready), 32'd0);
      end
      if (c == 6) begin
        chk("rstmid_c6_we", 32'(rf_we), 32'd0);
        chk("rstmid_c6_alu_ready", 32'(alu_ready), 32'd1);
        chk("rstmid_c6_mem_ready", 32'(mem_ready), 32'd1);
        chk("rstmid_c6_idle", 32'(idle), 32'd1);
        chk("rstmid_c6_hit_rs", 32'(q_hit_rs), 32'd0);
        chk("rstmid_c6_hit_rt", 32'(q_hit_rt), 32'd0);
      end
      cyc();
    end
    for (int c = 7; c <= 10; c++) begin
      smp();
      chk($sformatf("rstmid_c%0d_we", c), 32'(rf_we), 32'd0);
      cyc();
    end
    chk("final_queues_empty", 32'(exp_alu.size() + exp_mem.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
